// File: rtl/ram_burst_master.sv
// ram_burst_master: burst initiator for a single-port RAM with 1-cycle read latency.
// Write bursts stream beats straight into the RAM. Read bursts go through a
// 2-entry output FIFO plus one in-flight slot, so the consumer can apply backpressure.
// Optional feature macro: RAMCTL_PERF_EN adds the perf_stall counter port.
module ram_burst_master #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              m_cen,
    output logic              m_wen,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_din,
    input  logic [DATA_W-1:0] m_dout
`ifdef RAMCTL_PERF_EN
    ,
    output logic [31:0]       perf_stall
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_READ   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam int CNT_W = LEN_W + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  issue_left_q, issue_left_d;  // beats still to access in the RAM
    logic [CNT_W-1:0]  pop_left_q, pop_left_d;      // read beats still to hand to the consumer
    logic              inflight_q, inflight_d;      // a RAM read was issued last cycle
    logic [DATA_W-1:0] fifo_q [2];
    logic [DATA_W-1:0] fifo_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              pop_s;
    logic              issue_s;
    logic [2:0]        occ_s;

    // Read issue qualification: never let buffered + in-flight beats exceed the FIFO depth
    always_comb begin
        pop_s = (count_q != 2'd0) && rd_ready;
        occ_s = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
        if ((state_q == ST_READ) && (issue_left_q != {CNT_W{1'b0}}) && (occ_s < 3'd2)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Next-state, datapath updates and all handshake/RAM outputs
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        pop_left_d   = pop_left_q;
        inflight_d   = 1'b0;
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        cmd_ready    = 1'b0;
        wr_ready     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        m_cen        = 1'b0;
        m_wen        = 1'b0;
        m_addr       = {ADDR_W{1'b0}};
        m_din        = {DATA_W{1'b0}};
        rd_valid     = (count_q != 2'd0);
        rd_data      = fifo_q[rd_ptr_q];

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d       = cmd_addr;
                    issue_left_d = {1'b0, cmd_len} + CNT_W'(1);
                    pop_left_d   = {1'b0, cmd_len} + CNT_W'(1);
                    state_d      = cmd_wr ? ST_WRITE : ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                busy     = 1'b1;
                wr_ready = 1'b1;
                m_cen    = wr_valid;
                m_wen    = wr_valid;
                m_addr   = addr_q;
                m_din    = wr_data;
                if (wr_valid) begin
                    addr_d       = addr_q + ADDR_W'(1);
                    issue_left_d = issue_left_q - CNT_W'(1);
                    state_d      = (issue_left_q == CNT_W'(1)) ? ST_FINISH : ST_WRITE;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                busy       = 1'b1;
                m_cen      = issue_s;
                m_addr     = addr_q;
                inflight_d = issue_s;
                count_d    = count_q + {1'b0, inflight_q} - {1'b0, pop_s};
                if (issue_s) begin
                    addr_d       = addr_q + ADDR_W'(1);
                    issue_left_d = issue_left_q - CNT_W'(1);
                end else begin
                    addr_d = addr_q;
                end
                // RAM data is only meaningful the cycle after an issued read
                if (inflight_q) begin
                    fifo_d[wr_ptr_q] = m_dout;
                    wr_ptr_d         = ~wr_ptr_q;
                end else begin
                    wr_ptr_d = wr_ptr_q;
                end
                if (pop_s) begin
                    rd_ptr_d   = ~rd_ptr_q;
                    pop_left_d = pop_left_q - CNT_W'(1);
                    state_d    = (pop_left_q == CNT_W'(1)) ? ST_FINISH : ST_READ;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_FINISH: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any burst in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= {ADDR_W{1'b0}};
            issue_left_q <= {CNT_W{1'b0}};
            pop_left_q   <= {CNT_W{1'b0}};
            inflight_q   <= 1'b0;
            fifo_q[0]    <= {DATA_W{1'b0}};
            fifo_q[1]    <= {DATA_W{1'b0}};
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            pop_left_q   <= pop_left_d;
            inflight_q   <= inflight_d;
            fifo_q[0]    <= fifo_d[0];
            fifo_q[1]    <= fifo_d[1];
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

`ifdef RAMCTL_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Stall counter: busy cycles without a RAM access, saturating
    always_comb begin
        perf_d = perf_q;
        if (busy && !m_cen && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end else begin
            perf_d = perf_q;
        end
    end

    // Stall counter register, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= 32'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall = perf_q;
`endif

endmodule

// File: tb/tb_ram_burst_master.sv
// tb_ram_burst_master: directed bench with a behavioural 256x64 RAM and
// scoreboard queues for expected write beats, read addresses and read data.
module tb_ram_burst_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [63:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [63:0] rd_data;
    logic        busy;
    logic        done;
    logic        m_cen;
    logic        m_wen;
    logic [7:0]  m_addr;
    logic [63:0] m_din;
    logic [63:0] m_dout;
`ifdef RAMCTL_PERF_EN
    logic [31:0] perf_stall;
    logic [31:0] perf_at_done;
`endif

    ram_burst_master dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .m_cen     (m_cen),
        .m_wen     (m_wen),
        .m_addr    (m_addr),
        .m_din     (m_din),
        .m_dout    (m_dout)
`ifdef RAMCTL_PERF_EN
        ,
        .perf_stall(perf_stall)
`endif
    );

    // Behavioural single-port RAM, one-cycle read latency
    logic [63:0] mem [256];
    logic [63:0] exp_mem [256];

    always @(posedge clk) begin
        if (m_cen) begin
            if (m_wen) mem[m_addr] <= m_din;
            else       m_dout      <= mem[m_addr];
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int issued   = 0;
    int popped   = 0;
    logic cmd_hs, wr_hs, pop_now, vld_now, done_now;
    logic [7:0]  exp_wa [$];
    logic [63:0] exp_wd [$];
    logic [7:0]  exp_ra [$];
    logic [63:0] exp_rd [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: sample and score outputs at negedge, return just after posedge
    task automatic step();
        @(negedge clk);
        cmd_hs   = cmd_valid && cmd_ready;
        wr_hs    = wr_valid && wr_ready;
        pop_now  = rd_valid && rd_ready;
        vld_now  = rd_valid;
        done_now = done;
        if (done) begin
            done_cnt++;
`ifdef RAMCTL_PERF_EN
            perf_at_done = perf_stall;
`endif
        end
        if (m_cen && m_wen) begin
            check("wr_expected", 64'(exp_wa.size() > 0), 64'd1);
            if (exp_wa.size() > 0) begin
                check("wr_addr", 64'(m_addr), 64'(exp_wa.pop_front()));
                check("wr_data", m_din, exp_wd.pop_front());
            end
        end
        if (m_cen && !m_wen) begin
            issued++;
            check("rd_issue_expected", 64'(exp_ra.size() > 0), 64'd1);
            if (exp_ra.size() > 0) check("rd_addr", 64'(m_addr), 64'(exp_ra.pop_front()));
        end
        if (pop_now) begin
            popped++;
            check("rd_expected", 64'(exp_rd.size() > 0), 64'd1);
            if (exp_rd.size() > 0) check("rd_data", rd_data, exp_rd.pop_front());
        end
        if (m_cen && !m_wen) check("rd_occupancy_le2", 64'((issued - popped) <= 2), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [7:0] a, input logic [7:0] l);
        int t = 0;
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_len = l;
        step();
        while (!cmd_hs && t < 20) begin step(); t++; end
        check("cmd_accept", 64'(cmd_hs), 64'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (!done_now && t < 50) begin step(); t++; end
        check(tag, 64'(done_now), 64'd1);
    endtask

    task automatic write_burst(input logic [7:0] a, input int n, input logic [63:0] base, input int gap);
        int dc0 = done_cnt;
        for (int i = 0; i < n; i++) begin
            logic [7:0] ai = a + 8'(i);
            exp_wa.push_back(ai);
            exp_wd.push_back(base + 64'(i));
            exp_mem[ai] = base + 64'(i);
        end
        send_cmd(1'b1, a, 8'(n - 1));
        done_now = 1'b0;
        for (int i = 0; i < n; i++) begin
            int t = 1;
            wr_valid = 1'b1;
            wr_data  = base + 64'(i);
            step();
            while (!wr_hs && t < 20) begin step(); t++; end
            if (gap == 0) check("wr_consecutive", 64'(t), 64'd1);
            else          check("wr_accept", 64'(wr_hs), 64'd1);
            wr_valid = 1'b0;
            if (i == 0) repeat (gap) step();
        end
        if (!done_now) wait_done("wr_done");
        step(); step();
        check("wr_done_once", 64'(done_cnt - dc0), 64'd1);
        check("wr_queue_drained", 64'(exp_wa.size()), 64'd0);
    endtask

    task automatic read_burst(input logic [7:0] a, input int n, input int mode);
        int idx = 0, first = -1, lastpop = -1, doneidx = -1;
        int dc0 = done_cnt;
        logic [5:0] bp = 6'b101001;
        for (int i = 0; i < n; i++) begin
            logic [7:0] ai = a + 8'(i);
            exp_ra.push_back(ai);
            exp_rd.push_back(exp_mem[ai]);
        end
        send_cmd(1'b0, a, 8'(n - 1));
        while (doneidx < 0 && idx < 200) begin
            rd_ready = (mode == 0) ? 1'b1 : bp[idx % 6];
            step();
            if (vld_now && first < 0) first = idx;
            if (pop_now) lastpop = idx;
            if (done_now) doneidx = idx;
            idx++;
        end
        rd_ready = 1'b0;
        check("rd_done_seen", 64'(doneidx >= 0), 64'd1);
        if (mode == 0) begin
            check("rd_first_valid_cycle", 64'(first), 64'd2);
            check("rd_last_pop_cycle", 64'(lastpop), 64'(n + 1));
            check("rd_done_cycle", 64'(doneidx), 64'(n + 2));
        end
        step(); step();
        check("rd_done_once", 64'(done_cnt - dc0), 64'd1);
        check("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
    endtask

    initial begin
        int pops, t, dc0;
        for (int i = 0; i < 256; i++) begin mem[i] = 64'd0; exp_mem[i] = 64'd0; end
        m_dout = 64'd0;
        rst = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 8'd0; cmd_len = 8'd0;
        wr_valid = 1'b0; wr_data = 64'd0; rd_ready = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_wr_ready", 64'(wr_ready), 64'd0);
        check("rst_m_cen", 64'(m_cen), 64'd0);
        check("rst_m_wen", 64'(m_wen), 64'd0);
        check("rst_m_addr", 64'(m_addr), 64'd0);
        check("rst_m_din", m_din, 64'd0);
        check("rst_rd_data", rd_data, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // wr_valid in IDLE must be ignored
        wr_valid = 1'b1; wr_data = 64'hDEAD;
        #1;
        check("idle_wr_ready", 64'(wr_ready), 64'd0);
        check("idle_m_cen", 64'(m_cen), 64'd0);
        step();
        wr_valid = 1'b0;

        // Write burst 0x10..0x13
        write_burst(8'h10, 4, 64'hA0, 0);
        for (int i = 0; i < 4; i++) check("ram_content", mem[8'h10 + 8'(i)], 64'hA0 + 64'(i));

        // Read back with and without backpressure
        read_burst(8'h10, 4, 0);
        read_burst(8'h10, 4, 1);

        // Address wrap
        write_burst(8'hFE, 4, 64'd1, 0);
        check("wrap_ram_00", mem[8'h00], 64'd3);
        read_burst(8'hFE, 4, 0);
        read_burst(8'hFE, 4, 1);

        // Reset in the middle of an 8-beat read
        for (int i = 0; i < 8; i++) begin
            exp_ra.push_back(8'h20 + 8'(i));
            exp_rd.push_back(exp_mem[8'h20 + 8'(i)]);
        end
        send_cmd(1'b0, 8'h20, 8'd7);
        rd_ready = 1'b1;
        pops = 0; t = 0;
        while (pops < 2 && t < 20) begin step(); if (pop_now) pops++; t++; end
        check("midrst_two_pops", 64'(pops), 64'd2);
        dc0 = done_cnt;
        rst = 1'b1;
        #1;
        check("midrst_m_cen", 64'(m_cen), 64'd0);
        check("midrst_rd_valid", 64'(rd_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        exp_ra.delete(); exp_rd.delete();
        issued = 0; popped = 0;
        repeat (3) step();
        check("midrst_no_done", 64'(done_cnt - dc0), 64'd0);
        rst = 1'b0;
        rd_ready = 1'b0;
        #1;
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        read_burst(8'h12, 2, 0);

`ifdef RAMCTL_PERF_EN
        rst = 1'b1;
        #1;
        check("perf_rst", 64'(perf_stall), 64'd0);
        step();
        rst = 1'b0;
        write_burst(8'h40, 2, 64'h55, 3);
        check("perf_stall_at_done", 64'(perf_at_done), 64'd3);
`endif

        check("final_queues_empty", 64'(exp_wa.size() + exp_ra.size() + exp_rd.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_burst_master.md
Name: ram_burst_master

Overview:
- Initiator for the single-port 256x64 RAM (cen/wen/addr/din/dout port, 1-cycle read latency).
- Accepts burst commands on a valid/ready command channel. Streams write data from a valid/ready write channel into the RAM, or streams read data out on a valid/ready read channel with consumer backpressure.
- Sits between datapath/DMA logic and the RAM, so clients never handle RAM timing directly.

Parameters:
- ADDR_W, 8, RAM address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 64, RAM word width.
- LEN_W, 8, burst length field width; beats = cmd_len + 1 (1..256).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_wr  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  start address
- cmd_len  in  LEN_W  beats minus one
- wr_valid  in  1  write beat present
- wr_ready  out  1  write beat accepted
- wr_data  in  DATA_W  write beat data
- rd_valid  out  1  read beat present
- rd_ready  in  1  consumer accepts read beat
- rd_data  out  DATA_W  read beat data
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion
- m_cen  out  1  RAM chip enable
- m_wen  out  1  RAM write enable
- m_addr  out  ADDR_W  RAM address
- m_din  out  DATA_W  RAM write data
- m_dout  in  DATA_W  RAM read data, valid the cycle after a read access

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE; address, beat, in-flight and buffer registers are cleared.
  - busy=0, done=0, rd_valid=0, wr_ready=0, cmd_ready=1.
  - m_cen=0, m_wen=0, m_addr=0, m_din=0, rd_data=0.
  - Reset mid-burst abandons the burst with no done pulse.
- States: IDLE, WRITE, READ, FINISH.
- IDLE: cmd_ready=1. On cmd_valid, latch addr/len/dir; go to WRITE or READ next cycle; busy=1 from that cycle.
- WRITE:
  - wr_ready=1. m_cen = m_wen = wr_valid; m_addr = addr_q; m_din = wr_data (combinational).
  - Each accepted beat writes the RAM at that edge, increments addr_q with wrap 255->0, and decrements the remaining count.
  - Last beat accepted -> FINISH. Gaps in wr_valid stall without RAM access (m_cen=0).
- READ:
  - 2-entry output FIFO plus a 1-bit in-flight flag.
  - Issue a read (m_cen=1, m_wen=0, m_addr=addr_q) when beats remain to issue and (count + inflight - pop) < 2, where pop = rd_valid && rd_ready.
  - Data is captured from m_dout at the edge after issue.
  - rd_valid = (count != 0); rd_data = FIFO head.
  - Sustained throughput is 1 beat/cycle while rd_ready=1. First rd_valid appears 2 cycles after entering READ.
  - Beats are delivered in address order, and no beat is ever lost or duplicated under arbitrary rd_ready toggling.
  - All beats issued, captured and popped -> FINISH.
- FINISH: done=1 for exactly one cycle, busy=0, then IDLE. A new command is accepted no earlier than the cycle after FINISH.
- Inputs with no effect:
  - wr_valid outside WRITE is ignored (wr_ready=0).
  - cmd_valid outside IDLE is ignored.
  - m_dout is ignored unless a read is in flight.
- Wrap: a burst from 0xFE of 4 beats accesses 0xFE, 0xFF, 0x00, 0x01.

Optional Feature:
- Macro RAMCTL_PERF_EN.
- Defined:
  - Adds output port perf_stall [31:0].
  - Counts cycles in WRITE/READ with m_cen=0 (write starvation or read backpressure).
  - Saturates at 0xFFFFFFFF and clears only on rst.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Write burst: cmd wr=1, addr=0x10, len=3, data 0xA0..0xA3 with wr_valid held high -> 4 consecutive m_cen=m_wen=1 cycles at 0x10..0x13; done pulses once; RAM holds 0xA0..0xA3.
- Read burst, no backpressure: read addr=0x10, len=3, rd_ready=1 -> rd_data 0xA0,0xA1,0xA2,0xA3 on 4 consecutive cycles starting 2 cycles after READ entry; done follows the last beat.
- Read backpressure: same burst with rd_ready toggling 1,0,0,1,0,1,... -> identical ordered data, no drop or duplicate; at no point more than 2 buffered plus in-flight beats.
- Wrap: write addr=0xFE, len=3, data 1..4, then read back -> addresses 0xFE,0xFF,0x00,0x01 return 1,2,3,4.
- Reset mid-burst: assert rst during beat 2 of an 8-beat read -> m_cen=0 and rd_valid=0 immediately, no done; after release a new cmd is accepted with cmd_ready=1.
- RAMCTL_PERF_EN: write len=1 with a 3-cycle wr_valid gap -> perf_stall=3 at done.
